d_ff: RTL and testbench



---
 rtl/d_ff.sv | 29 ++
 tb/tb_d_ff.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_ff.sv
// d_ff: positive-edge D flip-flop with asynchronous active-low reset.
// Width and reset value are parameters. The default is a 1-bit flop that
// resets to 0. The port order d, clk, rst, q is fixed because existing
// benches connect this block by position.
module d_ff #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  // Storage: a falling rst forces RESET_VALUE at once, with no clock needed.
  // A rising clk edge while rst is still low takes the reset branch, so
  // reset always wins over the clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignment so every flop samples its inputs
      // before any of them update. Blocking assignments here would create
      // ordering races between flops.
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: self-checking bench for d_ff. It drives a 1-bit default instance
// and an 8-bit instance with a non-zero reset value from the same clk/rst.
// The expected outputs come from a behavioural model: after each rising edge
// the output is the d present at that edge, or the reset value while reset
// is held.
module tb_d_ff;

  localparam int unsigned      WW   = 8;
  localparam logic [WW-1:0]    WRST = 8'h5A;

  logic          clk;
  logic          rst;
  logic          d_n;
  logic          q_n;
  logic [WW-1:0] d_w;
  logic [WW-1:0] q_w;

  logic          exp_n;
  logic [WW-1:0] exp_w;

  int errors;
  int checks;

  d_ff u_dut (
    .d  (d_n),
    .clk(clk),
    .rst(rst),
    .q  (q_n)
  );

  d_ff #(.WIDTH(WW), .RESET_VALUE(WRST)) u_dut_w (
    .d  (d_w),
    .clk(clk),
    .rst(rst),
    .q  (q_w)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: time=%0t required finish before 50000", $time);
    $fatal(1, "watchdog expired");
  end

  // Wait for a rising edge, then step past it before sampling.
  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    d_n = 1'b0;
    d_w = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_n = 1'b1;
      d_w = 8'($urandom);
      #2;
      checks++;
      if ({q_w, q_n} !== {WRST, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid[%0d]: q=%b q_w=%h required q=0 q_w=%h", i, q_n, q_w, WRST);
      end
      after_rise();
      checks++;
      if ({q_w, q_n} !== {WRST, 1'b0}) begin
        errors++;
        $display("FAIL reset_edge[%0d]: q=%b q_w=%h required q=0 q_w=%h", i, q_n, q_w, WRST);
      end
      d_n = 1'b0;
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst = 1'b1;
    d_n = 1'b1;
    d_w = 8'hC3;
    after_rise();
    checks++;
    if ({q_w, q_n} !== {8'hC3, 1'b1}) begin
      errors++;
      $display("FAIL capture_one: q=%b q_w=%h required q=1 q_w=c3", q_n, q_w);
    end
    d_n = 1'b0;
    d_w = 8'h3C;
    @(negedge clk);
    #1;
    checks++;
    if ({q_w, q_n} !== {8'hC3, 1'b1}) begin
      errors++;
      $display("FAIL capture_falling_edge: q=%b q_w=%h required q=1 q_w=c3", q_n, q_w);
    end
    after_rise();
    checks++;
    if ({q_w, q_n} !== {8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL capture_zero: q=%b q_w=%h required q=0 q_w=3c", q_n, q_w);
    end
  endtask

  task automatic test_async_assert();
    @(negedge clk);
    d_n = 1'b1;
    d_w = 8'hFF;
    after_rise();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({q_w, q_n} !== {WRST, 1'b0}) begin
      errors++;
      $display("FAIL async_assert: q=%b q_w=%h required q=0 q_w=%h", q_n, q_w, WRST);
    end
    #1;
    rst = 1'b1;
  endtask

  task automatic test_pulse_reset();
    @(negedge clk);
    d_n = 1'b1;
    d_w = 8'h81;
    after_rise();
    rst = 1'b0;
    #1;
    checks++;
    if ({q_w, q_n} !== {WRST, 1'b0}) begin
      errors++;
      $display("FAIL pulse_low: q=%b q_w=%h required q=0 q_w=%h", q_n, q_w, WRST);
    end
    #4;
    rst = 1'b1;
    #1;
    checks++;
    if ({q_w, q_n} !== {WRST, 1'b0}) begin
      errors++;
      $display("FAIL pulse_release_hold: q=%b q_w=%h required q=0 q_w=%h", q_n, q_w, WRST);
    end
    after_rise();
    checks++;
    if ({q_w, q_n} !== {8'h81, 1'b1}) begin
      errors++;
      $display("FAIL pulse_next_edge: q=%b q_w=%h required q=1 q_w=81", q_n, q_w);
    end
  endtask

  task automatic test_reset_dominance();
    @(negedge clk);
    rst = 1'b0;
    d_n = 1'b1;
    d_w = 8'h77;
    for (int i = 0; i < 3; i++) begin
      after_rise();
      checks++;
      if ({q_w, q_n} !== {WRST, 1'b0}) begin
        errors++;
        $display("FAIL dominance_edge[%0d]: q=%b q_w=%h required q=0 q_w=%h", i, q_n, q_w, WRST);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({q_w, q_n} !== {WRST, 1'b0}) begin
      errors++;
      $display("FAIL dominance_release: q=%b q_w=%h required q=0 q_w=%h", q_n, q_w, WRST);
    end
    after_rise();
    checks++;
    if ({q_w, q_n} !== {8'h77, 1'b1}) begin
      errors++;
      $display("FAIL dominance_load: q=%b q_w=%h required q=1 q_w=77", q_n, q_w);
    end
  endtask

  task automatic test_glitch();
    d_n = 1'b1;
    d_w = 8'hAA;
    after_rise();
    d_n = 1'b0;
    d_w = 8'h11;
    #2;
    d_n = 1'b1;
    d_w = 8'h22;
    #2;
    checks++;
    if ({q_w, q_n} !== {8'hAA, 1'b1}) begin
      errors++;
      $display("FAIL glitch_hold: q=%b q_w=%h required q=1 q_w=aa", q_n, q_w);
    end
    d_n = 1'b0;
    d_w = 8'h44;
    after_rise();
    checks++;
    if ({q_w, q_n} !== {8'h44, 1'b0}) begin
      errors++;
      $display("FAIL glitch_final: q=%b q_w=%h required q=0 q_w=44", q_n, q_w);
    end
  endtask

  // Random data with occasional reset windows opened and closed away from
  // clock edges. The model tracks the value the flop should hold.
  task automatic test_random();
    exp_n = q_n === 1'b0 ? 1'b0 : 1'b0;
    exp_n = 1'b0;
    exp_w = 8'h44;
    for (int i = 0; i < 300; i++) begin
      // Now at rising edge + 1.
      #2;
      rst = ($urandom_range(0, 5) != 0);
      if (!rst) begin
        exp_n = 1'b0;
        exp_w = WRST;
      end
      #1;
      checks++;
      if ({q_w, q_n} !== {exp_w, exp_n}) begin
        errors++;
        $display("FAIL random_mid[%0d]: q=%b q_w=%h required q=%b q_w=%h", i, q_n, q_w, exp_n, exp_w);
      end
      d_n = 1'($urandom);
      d_w = 8'($urandom);
      #3;
      d_n = 1'($urandom);
      d_w = 8'($urandom);
      if (rst) begin
        exp_n = d_n;
        exp_w = d_w;
      end
      after_rise();
      checks++;
      if ({q_w, q_n} !== {exp_w, exp_n}) begin
        errors++;
        $display("FAIL random_edge[%0d]: q=%b q_w=%h required q=%b q_w=%h", i, q_n, q_w, exp_n, exp_w);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_capture();
    test_async_assert();
    test_pulse_reset();
    test_reset_dominance();
    test_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
